// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_ctrl_if : split address/response instruction-memory handshake   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface fetch_ctrl_if #(
  parameter int W = 32
);
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [31:0]  imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | fetch_ctrl : PC owner, single-outstanding fetch, squash, 1-entry slot |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module fetch_ctrl #(
  parameter int           W          = 32,
  parameter logic [W-1:0] RESET_PC   = '0,
  parameter logic [W-1:0] EXC_VECTOR = 'h0000_0180
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         stall,
  input  wire logic         exc_take,
  input  wire logic         br_take,
  input  wire logic         br_targ_or_offset,
  input  wire logic [W-1:0] br_targ,
  input  wire logic [W-1:0] br_pc,
  input  wire logic [W-1:0] br_offset,
  fetch_ctrl_if.master      imem,
  output logic [W-1:0]      pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [W-1:0]      inst_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t       r_state;
  logic         w_redirect;
  logic [W-1:0] w_target;
  logic         w_req;

  assign w_redirect = exc_take | br_take;

  always_comb begin
    w_target = br_pc + br_offset;
    if (exc_take)
      w_target = EXC_VECTOR;
    else if (br_targ_or_offset)
      w_target = br_targ;
  end

  // Issue only when the slot is free now or is being consumed at this edge,
  // so a later capture always lands in an empty slot.
  assign w_req = rst & (r_state == S_IDLE) & ~w_redirect & (~inst_valid | ~stall);

  assign imem.imem_req  = w_req;
  assign imem.imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      pc         <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      if (w_redirect || (inst_valid && !stall))
        inst_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_redirect)
            pc <= w_target;
          else if (w_req && imem.imem_gnt)
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid) begin
            r_state <= S_IDLE;
            if (w_redirect) begin
              pc <= w_target;
            end else begin
              inst       <= imem.imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              pc         <= pc + W'(4);
            end
          end else if (w_redirect) begin
            pc      <= w_target;
            r_state <= S_DROP;
          end
        end
        S_DROP: begin
          if (w_redirect)
            pc <= w_target;
          if (imem.imem_rvalid)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_fetch_ctrl : directed self-checking bench for fetch_ctrl           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        exc_take;
  logic        br_take;
  logic        br_targ_or_offset;
  logic [31:0] br_targ;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic [31:0] pc, inst, inst_pc;
  logic        inst_valid;
  logic [31:0] pc2, inst2, inst_pc2;
  logic        inst_valid2;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 1;

  fetch_ctrl_if #(.W(32)) mif ();
  fetch_ctrl_if #(.W(32)) mif2 ();

  fetch_ctrl #(.W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .exc_take(exc_take), .br_take(br_take),
    .br_targ_or_offset(br_targ_or_offset), .br_targ(br_targ), .br_pc(br_pc),
    .br_offset(br_offset), .imem(mif), .pc(pc), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc)
  );

  // Second instance exercises the wrapping reset PC with a zero-wait memory.
  fetch_ctrl #(.W(32), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .stall(1'b0), .exc_take(1'b0), .br_take(1'b0),
    .br_targ_or_offset(1'b0), .br_targ(32'h0), .br_pc(32'h0),
    .br_offset(32'h0), .imem(mif2), .pc(pc2), .inst_valid(inst_valid2),
    .inst(inst2), .inst_pc(inst_pc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory for dut: one outstanding request, response lat cycles after grant, data = address.
  initial begin
    logic        acc;
    logic [31:0] acc_addr, pend_addr;
    int          cnt;
    cnt = 0;
    pend_addr = '0;
    mif.imem_rvalid = 1'b0;
    mif.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc      = mif.imem_req & mif.imem_gnt;
      acc_addr = mif.imem_addr;
      @(posedge clk);
      #1;
      mif.imem_rvalid = 1'b0;
      if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          mif.imem_rvalid = 1'b1;
          mif.imem_rdata  = pend_addr;
        end
      end
      if (acc) begin
        pend_addr = acc_addr;
        cnt = lat - 1;
        if (cnt == 0) begin
          mif.imem_rvalid = 1'b1;
          mif.imem_rdata  = pend_addr;
        end
      end
    end
  end

  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    mif2.imem_gnt    = 1'b1;
    mif2.imem_rvalid = 1'b0;
    mif2.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      acc      = mif2.imem_req & mif2.imem_gnt;
      acc_addr = mif2.imem_addr;
      @(posedge clk);
      #1;
      mif2.imem_rvalid = acc;
      mif2.imem_rdata  = acc_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; exc_take = 1'b0; br_take = 1'b0;
    br_targ_or_offset = 1'b0; br_targ = '0; br_pc = '0; br_offset = '0;
    mif.imem_gnt = 1'b1;

    step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_req", mif.imem_req, 1'b0);
    chk("rst_pc2", pc2, 32'hFFFF_FFFC);

    step();
    rst = 1'b1;
    #1;
    chk("first_req", mif.imem_req, 1'b1);
    chk("first_addr", mif.imem_addr, 32'h0);
    chk("first_addr2", mif2.imem_addr, 32'hFFFF_FFFC);

    step();
    chk("wait_req", mif.imem_req, 1'b0);
    step();
    chk("cap0_valid", inst_valid, 1'b1);
    chk("cap0_inst", inst, 32'h0);
    chk("cap0_inst_pc", inst_pc, 32'h0);
    chk("cap0_pc", pc, 32'h4);
    chk("wrap_valid2", inst_valid2, 1'b1);
    chk("wrap_inst_pc2", inst_pc2, 32'hFFFF_FFFC);
    chk("wrap_inst2", inst2, 32'hFFFF_FFFC);
    chk("wrap_pc2", pc2, 32'h0);
    step();
    chk("gap0_valid", inst_valid, 1'b0);
    step();
    chk("cap1_valid", inst_valid, 1'b1);
    chk("cap1_inst", inst, 32'h4);
    chk("cap1_inst_pc", inst_pc, 32'h4);
    step();
    chk("gap1_valid", inst_valid, 1'b0);
    step();
    chk("cap2_valid", inst_valid, 1'b1);
    chk("cap2_inst", inst, 32'h8);
    chk("cap2_inst_pc", inst_pc, 32'h8);
    chk("cap2_pc", pc, 32'hC);

    stall = 1'b1;
    #1;
    chk("stall_req0", mif.imem_req, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_req", mif.imem_req, 1'b0);
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_inst", inst, 32'h8);
      chk("stall_inst_pc", inst_pc, 32'h8);
      chk("stall_pc", pc, 32'hC);
    end
    stall = 1'b0;
    lat = 3;
    #1;
    chk("unstall_req", mif.imem_req, 1'b1);
    chk("unstall_addr", mif.imem_addr, 32'hC);

    step();
    br_take = 1'b1; br_targ_or_offset = 1'b1; br_targ = 32'h400;
    #1;
    chk("wait_br_req", mif.imem_req, 1'b0);
    step();
    br_take = 1'b0;
    lat = 1;
    chk("drop_pc", pc, 32'h400);
    chk("drop_valid", inst_valid, 1'b0);
    chk("drop_req", mif.imem_req, 1'b0);
    step();
    chk("drop_valid_b", inst_valid, 1'b0);
    chk("drop_req_b", mif.imem_req, 1'b0);
    step();
    chk("discard_valid", inst_valid, 1'b0);
    chk("discard_pc", pc, 32'h400);
    chk("discard_req", mif.imem_req, 1'b1);
    chk("discard_addr", mif.imem_addr, 32'h400);
    step();
    step();
    chk("tgt_valid", inst_valid, 1'b1);
    chk("tgt_inst", inst, 32'h400);
    chk("tgt_inst_pc", inst_pc, 32'h400);
    chk("tgt_pc", pc, 32'h404);

    stall = 1'b1; exc_take = 1'b1; br_take = 1'b1; br_targ = 32'h400;
    #1;
    chk("exc_req", mif.imem_req, 1'b0);
    step();
    chk("exc_pc", pc, 32'h180);
    chk("exc_flush", inst_valid, 1'b0);
    exc_take = 1'b0; br_take = 1'b0; stall = 1'b0;
    #1;
    chk("exc_next_req", mif.imem_req, 1'b1);
    chk("exc_next_addr", mif.imem_addr, 32'h180);
    step();
    step();
    chk("exc_cap_valid", inst_valid, 1'b1);
    chk("exc_cap_inst_pc", inst_pc, 32'h180);
    chk("exc_cap_pc", pc, 32'h184);

    br_take = 1'b1; br_targ_or_offset = 1'b0; br_pc = 32'h100; br_offset = 32'hFFFF_FFF8;
    step();
    chk("off_pc", pc, 32'hF8);
    chk("off_flush", inst_valid, 1'b0);
    br_take = 1'b0;
    lat = 3;
    #1;
    chk("off_addr", mif.imem_addr, 32'hF8);

    step();
    chk("pre_rst_req", mif.imem_req, 1'b0);
    chk("pre_rst_inst_pc", inst_pc, 32'h180);
    #2;
    rst = 1'b0;
    mif.imem_gnt = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_valid", inst_valid, 1'b0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_inst_pc", inst_pc, 32'h0);
    chk("arst_req", mif.imem_req, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("arst_rel_req", mif.imem_req, 1'b1);
    step();
    step();
    chk("stray_valid", inst_valid, 1'b0);
    chk("stray_pc", pc, 32'h0);
    mif.imem_gnt = 1'b1;
    lat = 1;
    step();
    step();
    chk("post_valid", inst_valid, 1'b1);
    chk("post_inst", inst, 32'h0);
    chk("post_inst_pc", inst_pc, 32'h0);
    chk("post_pc", pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
